// File: rtl/bcd_updown_counter_if.sv
// Bundles the control inputs and registered outputs of the two-digit
// BCD up/down counter.
//   master modport: drives en, up, load, load_val; observes the outputs
//   slave  modport: the counter itself
//   en       count enable
//   up       direction, 1 = increment, 0 = decrement
//   load     synchronous load request (wins over en)
//   load_val BCD value to load, [7:4] tens, [3:0] ones
//   ones     registered BCD ones digit
//   tens     registered BCD tens digit
//   tc       terminal-count pulse
//   chg      value-changed strobe
//   load_err rejected-load pulse
interface bcd_updown_counter_if;
  logic       en;
  logic       up;
  logic       load;
  logic [7:0] load_val;
  logic [3:0] ones;
  logic [3:0] tens;
  logic       tc;
  logic       chg;
  logic       load_err;

  modport master (
    output en, up, load, load_val,
    input  ones, tens, tc, chg, load_err
  );

  modport slave (
    input  en, up, load, load_val,
    output ones, tens, tc, chg, load_err
  );
endinterface

// File: rtl/bcd_updown_counter.sv
// Two-digit BCD up/down counter, 00..99, with synchronous load.
// SATURATE = 0 wraps at the limits, SATURATE = 1 holds there.
// Every output is a register, so nothing passes combinationally
// from the inputs to the outputs.
//   clk   single clock, rising edge
//   rst_n asynchronous active-low reset, clears all outputs
//   bus   slave side of bcd_updown_counter_if (controls + outputs)
module bcd_updown_counter #(
  parameter bit SATURATE = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  bcd_updown_counter_if.slave    bus
);

  logic [3:0] nxt_ones;
  logic [3:0] nxt_tens;
  logic       at_limit;
  logic       load_ok;

  function automatic logic digit_ok(input logic [3:0] d);
    return d <= 4'd9;
  endfunction

  assign load_ok = digit_ok(bus.load_val[7:4]) && digit_ok(bus.load_val[3:0]);

  // Next count value. The ones digit rolls 9->0 (or 0->9) and carries or
  // borrows into tens on the same edge; at_limit marks 99 going up or
  // 00 going down, where a wrap happens or saturation holds.
  always_comb begin
    nxt_ones = bus.ones;
    nxt_tens = bus.tens;
    at_limit = 1'b0;
    if (bus.up) begin
      at_limit = (bus.tens == 4'd9) && (bus.ones == 4'd9);
      if (bus.ones == 4'd9) begin
        nxt_ones = 4'd0;
        nxt_tens = (bus.tens == 4'd9) ? 4'd0 : bus.tens + 4'd1;
      end else begin
        nxt_ones = bus.ones + 4'd1;
      end
    end else begin
      at_limit = (bus.tens == 4'd0) && (bus.ones == 4'd0);
      if (bus.ones == 4'd0) begin
        nxt_ones = 4'd9;
        nxt_tens = (bus.tens == 4'd0) ? 4'd9 : bus.tens - 4'd1;
      end else begin
        nxt_ones = bus.ones - 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.ones     <= 4'd0;
      bus.tens     <= 4'd0;
      bus.tc       <= 1'b0;
      bus.chg      <= 1'b0;
      bus.load_err <= 1'b0;
    end else begin
      // Strobes default low so each lasts exactly one cycle per event.
      bus.tc       <= 1'b0;
      bus.chg      <= 1'b0;
      bus.load_err <= 1'b0;
      if (bus.load) begin
        if (load_ok) begin
          bus.tens <= bus.load_val[7:4];
          bus.ones <= bus.load_val[3:0];
          bus.chg  <= (bus.load_val != {bus.tens, bus.ones});
        end else begin
          bus.load_err <= 1'b1;
        end
      end else if (bus.en) begin
        if (at_limit && SATURATE) begin
          // Held at the limit: the attempt is flagged, the value does not move.
          bus.tc <= 1'b1;
        end else begin
          bus.tens <= nxt_tens;
          bus.ones <= nxt_ones;
          bus.chg  <= 1'b1;
          bus.tc   <= at_limit;
        end
      end
    end
  end

endmodule

// File: tb/tb_bcd_updown_counter.sv
module tb_bcd_updown_counter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  bcd_updown_counter_if bus_w ();
  bcd_updown_counter_if bus_s ();

  bcd_updown_counter #(.SATURATE(1'b0)) dut_w (.clk(clk), .rst_n(rst_n), .bus(bus_w));
  bcd_updown_counter #(.SATURATE(1'b1)) dut_s (.clk(clk), .rst_n(rst_n), .bus(bus_s));

  typedef struct {
    logic [10:0] e0;
    logic [10:0] e1;
    string       nm;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Packed expectation: {tens, ones, tc, chg, load_err}
  function automatic logic [10:0] mk(input int t, input int o, input int tc,
                                     input int chg, input int err);
    return {4'(t), 4'(o), 1'(tc), 1'(chg), 1'(err)};
  endfunction

  function automatic logic [10:0] act_w();
    return {bus_w.tens, bus_w.ones, bus_w.tc, bus_w.chg, bus_w.load_err};
  endfunction

  function automatic logic [10:0] act_s();
    return {bus_s.tens, bus_s.ones, bus_s.tc, bus_s.chg, bus_s.load_err};
  endfunction

  task automatic check(input string nm, input logic [10:0] act, input logic [10:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got t=%h o=%h tc=%b chg=%b err=%b, want t=%h o=%h tc=%b chg=%b err=%b",
               nm, act[10:7], act[6:3], act[2], act[1], act[0],
               exp[10:7], exp[6:3], exp[2], exp[1], exp[0]);
    end
  endtask

  // Drive both counters at the falling edge and queue what the following
  // rising edge must produce. rel releases reset at this same falling edge.
  task automatic step(input logic e, input logic u, input logic l,
                      input logic [7:0] lv, input logic [10:0] x0,
                      input logic [10:0] x1, input string nm, input bit rel);
    exp_t x;
    @(negedge clk);
    bus_w.en = e; bus_w.up = u; bus_w.load = l; bus_w.load_val = lv;
    bus_s.en = e; bus_s.up = u; bus_s.load = l; bus_s.load_val = lv;
    x.e0 = x0; x.e1 = x1; x.nm = nm;
    q.push_back(x);
    if (rel) rst_n = 1'b1;
  endtask

  // Monitor: outputs are valid every cycle, sampled 2 time units after the edge.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #2;
      if (q.size() > 0) begin
        x = q.pop_front();
        check({x.nm, "_wrap"}, act_w(), x.e0);
        check({x.nm, "_sat"},  act_s(), x.e1);
        n_cmp++;
        if (bus_w.ones > 4'd9 || bus_w.tens > 4'd9 ||
            bus_s.ones > 4'd9 || bus_s.tens > 4'd9) begin
          n_bad++;
          $display("FAIL %s_range: got w=%h%h s=%h%h, want digits <= 9",
                   x.nm, bus_w.tens, bus_w.ones, bus_s.tens, bus_s.ones);
        end
      end
    end
  end

  initial begin
    logic [10:0] z;
    int v, v1, budget;
    z = mk(0, 0, 0, 0, 0);
    bus_w.en = 0; bus_w.up = 0; bus_w.load = 0; bus_w.load_val = 8'h00;
    bus_s.en = 0; bus_s.up = 0; bus_s.load = 0; bus_s.load_val = 8'h00;

    // Held in reset: counting and loading are ignored.
    step(1, 1, 0, 8'h00, z, z, "rst_en", 0);
    step(0, 0, 1, 8'h55, z, z, "rst_load", 0);
    step(0, 0, 0, 8'h00, z, z, "rst_release", 1);

    // 100 up counts: wrap counter runs 01..99,00; saturating one sticks at 99.
    for (int k = 1; k <= 100; k++) begin
      v  = k % 100;
      v1 = (k > 99) ? 99 : k;
      step(1, 1, 0, 8'h00,
           mk(v / 10, v % 10, (k == 100), 1, 0),
           mk(v1 / 10, v1 % 10, (k == 100), (k < 100), 0), "sweep", 0);
    end

    step(0, 0, 1, 8'h09, mk(0, 9, 0, 1, 0), mk(0, 9, 0, 1, 0), "load09", 0);
    step(1, 1, 0, 8'h00, mk(1, 0, 0, 1, 0), mk(1, 0, 0, 1, 0), "carry", 0);
    step(0, 0, 1, 8'h00, mk(0, 0, 0, 1, 0), mk(0, 0, 0, 1, 0), "load00", 0);
    step(1, 0, 0, 8'h00, mk(9, 9, 1, 1, 0), mk(0, 0, 1, 0, 0), "down_lim", 0);
    step(0, 0, 1, 8'h3A, mk(9, 9, 0, 0, 1), mk(0, 0, 0, 0, 1), "bad3A", 0);
    step(0, 0, 1, 8'hA3, mk(9, 9, 0, 0, 1), mk(0, 0, 0, 0, 1), "badA3", 0);
    step(1, 1, 1, 8'h55, mk(5, 5, 0, 1, 0), mk(5, 5, 0, 1, 0), "load_en", 0);
    step(0, 0, 1, 8'h55, mk(5, 5, 0, 0, 0), mk(5, 5, 0, 0, 0), "load_same", 0);
    step(0, 1, 0, 8'h00, mk(5, 5, 0, 0, 0), mk(5, 5, 0, 0, 0), "idle", 0);
    step(0, 0, 1, 8'h99, mk(9, 9, 0, 1, 0), mk(9, 9, 0, 1, 0), "load99", 0);
    step(1, 1, 0, 8'h00, mk(0, 0, 1, 1, 0), mk(9, 9, 1, 0, 0), "up_lim", 0);
    step(1, 1, 0, 8'h00, mk(0, 1, 0, 1, 0), mk(9, 9, 1, 0, 0), "up_again", 0);
    step(0, 0, 1, 8'h40, mk(4, 0, 0, 1, 0), mk(4, 0, 0, 1, 0), "load40", 0);
    step(1, 0, 0, 8'h00, mk(3, 9, 0, 1, 0), mk(3, 9, 0, 1, 0), "borrow", 0);
    step(0, 0, 1, 8'h47, mk(4, 7, 0, 1, 0), mk(4, 7, 0, 1, 0), "load47", 0);

    // Asynchronous reset between edges while chg from the load is still high.
    @(negedge clk);
    bus_w.en = 1; bus_w.up = 1; bus_w.load = 0;
    bus_s.en = 1; bus_s.up = 1; bus_s.load = 0;
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_wrap", act_w(), z);
    check("async_rst_sat",  act_s(), z);

    step(1, 1, 0, 8'h00, z, z, "rst_mid_hold", 0);
    step(1, 1, 0, 8'h00, mk(0, 1, 0, 1, 0), mk(0, 1, 0, 1, 0), "resume", 1);
    step(0, 0, 0, 8'h00, mk(0, 1, 0, 0, 0), mk(0, 1, 0, 0, 0), "final_idle", 0);

    budget = 0;
    while (q.size() > 0 && budget < 20) begin
      @(posedge clk);
      budget++;
    end
    #5;
    if (q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: got %0d pending, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bcd_updown_counter.md
BCD_UPDOWN_COUNTER -- requirements
Module: bcd_updown_counter

Interface
REQ-001 SHALL have parameter SATURATE, default 0: 0 = count wraps at limits, 1 = count holds at limits.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port en  input  1  count enable, sampled at the rising clk edge.
REQ-005 SHALL have port up  input  1  direction: 1 = increment, 0 = decrement.
REQ-006 SHALL have port load  input  1  synchronous load request.
REQ-007 SHALL have port load_val  input  8  BCD value to load: [7:4] tens, [3:0] ones.
REQ-008 SHALL have port ones  output  4  registered BCD ones digit; drives the downstream BCD-to-Excess-3 converter inputs A..D (ones[3] = A).
REQ-009 SHALL have port tens  output  4  registered BCD tens digit.
REQ-010 SHALL have port tc  output  1  terminal-count pulse.
REQ-011 SHALL have port chg  output  1  value-changed strobe.
REQ-012 SHALL have port load_err  output  1  rejected-load pulse.

Function
REQ-013 SHALL keep all outputs registered, with no combinational path from inputs to outputs.
REQ-014 SHALL hold ones and tens in 0..9 at all times; codes 10..15 never appear on either output.
REQ-015 SHALL give load priority over en when both are high in the same cycle; the en request is ignored for that cycle.
REQ-016 SHALL, on load with both load_val nibbles <= 9, set {tens,ones} = load_val at that edge, with load_err = 0.
REQ-017 SHALL, on load with either nibble > 9, leave {tens,ones} unchanged and drive load_err = 1 for exactly one cycle.
REQ-018 SHALL, on en=1 and up=1, increment ones; ones 9 -> 0 SHALL carry into tens in the same edge (e.g. 09 -> 10, 39 -> 40).
REQ-019 SHALL, on en=1 and up=0, decrement ones; ones 0 -> 9 SHALL borrow from tens in the same edge (e.g. 40 -> 39).
REQ-020 SHALL, when SATURATE=0, wrap 99 -> 00 on increment and 00 -> 99 on decrement.
REQ-021 SHALL, when SATURATE=1, hold at 99 on increment and hold at 00 on decrement.
REQ-022 SHALL assert tc for exactly one cycle, from the edge at which a wrap occurs (SATURATE=0) or an enabled count is attempted at the limit (SATURATE=1).
REQ-023 SHALL keep tc low after load, including a load of 00 or 99.
REQ-024 SHALL assert chg for one cycle after any edge at which {tens,ones} changed value, whether by count or by load.
REQ-025 SHALL keep chg low when a load writes the current value or when a saturated count holds.
REQ-026 SHALL, when en=0 and load=0, hold {tens,ones}, with tc, chg and load_err low.
REQ-027 SHALL never leave tc, chg or load_err high for more than one cycle, except when consecutive qualifying events occur on consecutive edges.

Reset
REQ-028 SHALL, on rst_n low, immediately (without waiting for clk) clear ones, tens, tc, chg and load_err to 0.
REQ-029 SHALL hold all outputs at 0 while rst_n is low, ignoring en and load.
REQ-030 SHALL resume counting on the first rising clk edge after rst_n deasserts; a mid-count reset SHALL discard any in-progress pulse.

Verification
REQ-031 SHALL cover: reset, then en=1, up=1 for 100 cycles (SATURATE=0) -> sequence 00..99, 00; tc high only in the cycle showing 00; chg high every cycle.
REQ-032 SHALL cover: load_val=8'h09, then one up count -> 09 then 10, tens carry, tc=0, chg=1 on both edges.
REQ-033 SHALL cover: count at 00, en=1, up=0 -> 99 with tc=1 (SATURATE=0); same with SATURATE=1 -> stays 00, tc=1, chg=0.
REQ-034 SHALL cover: load_val=8'h3A and load_val=8'hA3 -> value unchanged, load_err=1 for one cycle, chg=0.
REQ-035 SHALL cover: load=1 and en=1 together with load_val=8'h55 -> 55, not 56 or 54.
REQ-036 SHALL cover: rst_n pulled low between clock edges at count 47 -> outputs 00 before the next edge; ones always <= 9, matching the downstream Excess-3 input range.
